// File: rtl/count_issuer_pkg.sv
// Shared defaults and FSM encoding for the count issuer.
package count_issuer_pkg;

    localparam int DEF_DATA_W    = 6;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_TO_MARGIN = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/count_issuer_if.sv
// Bus between the count issuer, its command writer and the down-counter.
//
// Handshake: wr_en is a one-cycle push request with wr_data; there is no
// ready. The request is refused when the FIFO is full or wr_data is zero,
// and the refusal is reported by a one-cycle rej pulse in the following
// cycle. ena is a one-cycle load strobe qualifying din; oflag is a one-cycle
// pulse from the down-counter when it reaches zero.
interface count_issuer_if
    import count_issuer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              rej;
    logic [DATA_W-1:0] din;
    logic              ena;
    logic              oflag;
    logic              busy;
    logic              err;

    // Issuer side
    modport slave (
        input  wr_en, wr_data, oflag,
        output full, rej, din, ena, busy, err
    );

    // Writer/counter side
    modport master (
        output wr_en, wr_data, oflag,
        input  full, rej, din, ena, busy, err
    );
endinterface

// File: rtl/issue_fifo.sv
// Command FIFO holding values waiting to be issued to the down-counter.
// Push is ignored when full and pop when empty; the caller gates both.
module issue_fifo #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic [AW:0]       count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/count_issuer.sv
// Issues queued count values to an external down-counter one at a time,
// waits for its zero pulse, and flags a sticky error if it never arrives.
module count_issuer
    import count_issuer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int TO_MARGIN = DEF_TO_MARGIN
) (
    input  logic           clk,
    input  logic           rst_n,
    count_issuer_if.slave  bus,
    output state_t         state_o
);
    // Wide enough for the largest load value plus the timeout margin.
    localparam int TMR_W = $clog2((1 << DATA_W) + TO_MARGIN) + 1;

    state_t            state_q;
    logic [TMR_W-1:0]  timer_q;
    logic [TMR_W-1:0]  to_limit;
    logic [DATA_W-1:0] din_q;
    logic              ena_q;
    logic              busy_q;
    logic              err_q;
    logic              rej_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              wr_bad;

    // Zero values and writes while full are dropped, even if a pop frees a
    // slot in the same cycle.
    assign wr_bad    = bus.wr_en && ((bus.wr_data == '0) || fifo_full);
    assign fifo_push = bus.wr_en && !wr_bad;
    // Head is consumed on the edge that leaves LOAD.
    assign fifo_pop  = (state_q == ST_LOAD);
    assign to_limit  = {{(TMR_W-DATA_W){1'b0}}, din_q} + TMR_W'(TO_MARGIN);

    issue_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (bus.wr_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Issue FSM with WAIT timer; all outputs are registered alongside state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            din_q   <= '0;
            ena_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ena_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= ST_LOAD;
                        ena_q   <= 1'b1;
                        din_q   <= fifo_head;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_WAIT;
                    timer_q <= '0;
                end
                ST_WAIT: begin
                    if (bus.oflag) begin
                        if (!fifo_empty) begin
                            state_q <= ST_LOAD;
                            ena_q   <= 1'b1;
                            din_q   <= fifo_head;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (timer_q == to_limit - TMR_W'(1)) begin
                        // Counter never answered: give up and keep going.
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle refusal pulse for the previous cycle's write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rej_q <= 1'b0;
        else        rej_q <= wr_bad;
    end

    assign bus.full = fifo_full;
    assign bus.rej  = rej_q;
    assign bus.din  = din_q;
    assign bus.ena  = ena_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;
    assign state_o  = state_q;
endmodule

// File: doc/count_issuer.md
COUNT_ISSUER -- requirements
Module: count_issuer

Interface
REQ-001 Parameter DATA_W, default 6, width of load values and din.
REQ-002 Parameter DEPTH, default 4, command FIFO entries (power of two).
REQ-003 Parameter TO_MARGIN, default 4, extra WAIT cycles allowed beyond the loaded value before timeout.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 wr_en  input  1  push request for wr_data.
REQ-007 wr_data  input  DATA_W  count value to issue.
REQ-008 full  output  1  FIFO holds DEPTH entries.
REQ-009 rej  output  1  one-cycle pulse: last wr_en was refused (full or zero value).
REQ-010 din  output  DATA_W  load value presented to the down-counter.
REQ-011 ena  output  1  one-cycle load strobe to the down-counter.
REQ-012 oflag  input  1  counter-reached-zero pulse from the down-counter.
REQ-013 busy  output  1  high in states LOAD and WAIT.
REQ-014 err  output  1  sticky timeout flag.

Function
REQ-015 The block SHALL feed a down-counter (load on ena, count to 0, pulse oflag) from a DEPTH-entry FIFO, one value at a time.
REQ-016 FSM states SHALL be IDLE, LOAD, WAIT; all outputs registered or decoded from state (Moore).
REQ-017 IDLE -> LOAD when FIFO non-empty; otherwise stay IDLE.
REQ-018 LOAD lasts exactly one cycle: ena=1, din=FIFO head, head popped at the edge leaving LOAD, next state WAIT.
REQ-019 WAIT -> LOAD when oflag=1 and FIFO non-empty; WAIT -> IDLE when oflag=1 and FIFO empty.
REQ-020 WAIT timer SHALL clear on entry; WAIT -> IDLE with err set when timer reaches din+TO_MARGIN without oflag.
REQ-021 oflag outside WAIT SHALL be ignored (no state change, no error).
REQ-022 din SHALL hold its last issued value outside LOAD.
REQ-023 A write with wr_data=0 SHALL be discarded and rej pulsed the following cycle.
REQ-024 A write while full=1 SHALL be discarded and rej pulsed, including when a pop occurs in the same cycle (no pass-through).
REQ-025 Simultaneous accepted write and pop SHALL leave occupancy unchanged and preserve order.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-027 Latency: a write accepted at edge E0 into an empty FIFO in IDLE SHALL give ena=1 in the cycle after edge E1.
REQ-028 err SHALL remain set until reset; operation continues normally after a timeout.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, ena=0, din=0, busy=0, err=0, rej=0, full=0, FIFO empty, timer 0.
REQ-030 Reset during LOAD or WAIT SHALL drop the in-flight and queued values; no ena after release until a new write.
REQ-031 First state change SHALL occur no earlier than the first rising edge with rst_n=1.

Structure
REQ-032 Package count_issuer_pkg SHALL hold default DATA_W, DEPTH, TO_MARGIN and the FSM state encoding.
REQ-033 The FIFO SHALL be sub-module issue_fifo (push, pop, head, full, empty); FSM and timer stay in count_issuer.

Verification
REQ-034 Write 8 in IDLE -> ena high one cycle, din=8, two cycles after write edge; oflag after 8 cycles -> IDLE, busy=0.
REQ-035 Write 8,16,3 back-to-back -> three ena pulses in order 8,16,3, each the cycle after the preceding oflag.
REQ-036 Five writes while WAIT blocked -> fifth rejected, full=1, rej pulse; write 0 -> rej pulse, nothing queued.
REQ-037 Write 8, never return oflag -> err=1 after 12 WAIT cycles, state IDLE; next write 5 still issued normally.
REQ-038 Reset asserted in WAIT with 2 queued -> ena=0, busy=0, full=0 immediately; no ena after release without a write.
REQ-039 Spurious oflag in IDLE -> no state change, err=0.
